// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_pkg;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam int         PERF_CNT_W = 32;

  // HOLD_BR remembers a taken branch whose flush was deferred by a memory freeze.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    HOLD_BR = 2'd2
  } hazard_state_e;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high reset.
module sat_counter
  import hazard_pkg::*;
#(
  parameter int W = PERF_CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_full;

  assign w_full = &r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (i_en && !w_full) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_unit.sv
// Load-use / branch / memory-freeze hazard control with Mealy outputs.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit
  import hazard_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] IF_ID_Rs1_i,
  input  logic [4:0] IF_ID_Rs2_i,
  input  logic [4:0] ID_EX_Rd_i,
  input  logic       ID_EX_MemRead_i,
  input  logic       Branch_taken_i,
  input  logic       mem_busy_i,
  output logic       NoOp_o,
  output logic       Stall_o,
  output logic       PCWrite_o,
  output logic       Flush_o,
  output logic       Hold_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] StallCnt_o,
  output logic [PERF_CNT_W-1:0] HoldCnt_o,
  output logic [PERF_CNT_W-1:0] FlushCnt_o
`endif
);

  hazard_state_e r_state;
  hazard_state_e w_state_nxt;
  logic          w_load_use;

  assign w_load_use = ID_EX_MemRead_i && (ID_EX_Rd_i != REG_ZERO) &&
                      ((ID_EX_Rd_i == IF_ID_Rs1_i) || (ID_EX_Rd_i == IF_ID_Rs2_i));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    NoOp_o      = 1'b0;
    Stall_o     = 1'b0;
    PCWrite_o   = 1'b1;
    Flush_o     = 1'b0;
    Hold_o      = 1'b0;
    if (rst_i) begin
      NoOp_o      = 1'b1;
      PCWrite_o   = 1'b0;
      w_state_nxt = RUN;
    end else if (mem_busy_i) begin
      Hold_o    = 1'b1;
      Stall_o   = 1'b1;
      PCWrite_o = 1'b0;
      if (r_state == HOLD_BR) begin
        w_state_nxt = HOLD_BR;
      end else if (Branch_taken_i && !w_load_use) begin
        w_state_nxt = HOLD_BR;
      end else begin
        w_state_nxt = HOLD;
      end
    end else if (r_state == HOLD_BR) begin
      // Deferred flush fires exactly once as the freeze lifts.
      Flush_o     = 1'b1;
      w_state_nxt = RUN;
    end else begin
      w_state_nxt = RUN;
      if (w_load_use) begin
        NoOp_o    = 1'b1;
        Stall_o   = 1'b1;
        PCWrite_o = 1'b0;
      end else if (Branch_taken_i) begin
        Flush_o = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic w_bubble;

  // Counts only genuine load-use bubbles, not the reset-forced NoOp.
  assign w_bubble = !rst_i && !mem_busy_i && (r_state != HOLD_BR) && w_load_use;

  sat_counter #(.W(PERF_CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_en  (w_bubble),
    .o_cnt (StallCnt_o)
  );

  sat_counter #(.W(PERF_CNT_W)) u_hold_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_en  (Hold_o),
    .o_cnt (HoldCnt_o)
  );

  sat_counter #(.W(PERF_CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_en  (Flush_o),
    .o_cnt (FlushCnt_o)
  );
`endif

endmodule
